// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch (read-only) and load/store.
// One transaction in flight; registered outputs; timeout turns a silent memory into an error response.
module mem_port_arbiter #(
    parameter int MEM_DEPTH  = 8,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16,
    localparam int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  i_resp_valid,
    output logic                  i_err,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_resp_valid,
    output logic                  d_err,
    output logic                  mem_req_valid,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_data_valid,
    output logic                  busy,
    output logic                  owner
);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

    state_e                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    owner_q, owner_d;
    logic                    last_owner_q, last_owner_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic                    mem_we_q, mem_we_d;
    logic                    mem_req_valid_q, mem_req_valid_d;
    logic                    busy_q, busy_d;
    logic [DATA_WIDTH-1:0]   i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
    logic                    i_err_q, i_err_d, d_err_q, d_err_d;
    logic                    i_resp_q, i_resp_d, d_resp_q, d_resp_d;

    logic any_req, grant_data, timeout_hit;

    assign any_req     = i_req | d_req;
    // On a tie the port that did not win last time gets the grant.
    assign grant_data  = d_req & (~i_req | ~last_owner_q);
    assign timeout_hit = (cnt_q == TO_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            owner_q         <= 1'b0;
            last_owner_q    <= 1'b1;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
            mem_we_q        <= 1'b0;
            mem_req_valid_q <= 1'b0;
            busy_q          <= 1'b0;
            i_rdata_q       <= '0;
            d_rdata_q       <= '0;
            i_err_q         <= 1'b0;
            d_err_q         <= 1'b0;
            i_resp_q        <= 1'b0;
            d_resp_q        <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            owner_q         <= owner_d;
            last_owner_q    <= last_owner_d;
            mem_addr_q      <= mem_addr_d;
            mem_wdata_q     <= mem_wdata_d;
            mem_we_q        <= mem_we_d;
            mem_req_valid_q <= mem_req_valid_d;
            busy_q          <= busy_d;
            i_rdata_q       <= i_rdata_d;
            d_rdata_q       <= d_rdata_d;
            i_err_q         <= i_err_d;
            d_err_q         <= d_err_d;
            i_resp_q        <= i_resp_d;
            d_resp_q        <= d_resp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (any_req) state_d = REQ;
            REQ:     if (mem_data_valid || timeout_hit) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are computed one cycle ahead so every port comes straight from a flop.
    always_comb begin
        cnt_d           = '0;
        owner_d         = owner_q;
        last_owner_d    = last_owner_q;
        mem_addr_d      = mem_addr_q;
        mem_wdata_d     = mem_wdata_q;
        mem_we_d        = 1'b0;
        mem_req_valid_d = 1'b0;
        busy_d          = 1'b0;
        i_rdata_d       = i_rdata_q;
        d_rdata_d       = d_rdata_q;
        i_err_d         = i_err_q;
        d_err_d         = d_err_q;
        i_resp_d        = 1'b0;
        d_resp_d        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    owner_d         = grant_data;
                    last_owner_d    = grant_data;
                    mem_addr_d      = grant_data ? d_addr : i_addr;
                    mem_we_d        = grant_data & d_we;
                    if (grant_data) mem_wdata_d = d_wdata;
                    mem_req_valid_d = 1'b1;
                    busy_d          = 1'b1;
                end
            end
            REQ: begin
                busy_d = 1'b1;
                if (mem_data_valid || timeout_hit) begin
                    if (owner_q) begin
                        d_resp_d = 1'b1;
                        d_err_d  = ~mem_data_valid;
                        if (!mem_data_valid) d_rdata_d = '0;
                        else if (!mem_we_q)  d_rdata_d = mem_rdata;
                    end else begin
                        i_resp_d = 1'b1;
                        i_err_d  = ~mem_data_valid;
                        i_rdata_d = mem_data_valid ? mem_rdata : '0;
                    end
                end else begin
                    mem_req_valid_d = 1'b1;
                    mem_we_d        = mem_we_q;
                    cnt_d           = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign i_rdata       = i_rdata_q;
    assign i_resp_valid  = i_resp_q;
    assign i_err         = i_err_q;
    assign d_rdata       = d_rdata_q;
    assign d_resp_valid  = d_resp_q;
    assign d_err         = d_err_q;
    assign mem_req_valid = mem_req_valid_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign busy          = busy_q;
    assign owner         = owner_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs driven and outputs sampled on the falling edge.
module tb_mem_port_arbiter;
    localparam int AW = 3;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_req, d_req, d_we, mem_data_valid;
    logic [AW-1:0] i_addr, d_addr, mem_addr;
    logic [DW-1:0] d_wdata, mem_rdata, i_rdata, d_rdata, mem_wdata;
    logic          i_resp_valid, i_err, d_resp_valid, d_err;
    logic          mem_req_valid, mem_we, busy, owner;

    int vectors = 0;
    int miscompares = 0;

    mem_port_arbiter #(.MEM_DEPTH(8), .DATA_WIDTH(32), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata),
        .i_resp_valid(i_resp_valid), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp_valid(d_resp_valid), .d_err(d_err),
        .mem_req_valid(mem_req_valid), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_data_valid(mem_data_valid),
        .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; i_req = 0; d_req = 0; d_we = 0; i_addr = '0; d_addr = '0;
        d_wdata = '0; mem_rdata = '0; mem_data_valid = 0;
        tick(); tick();
        vectors++;
        if ({i_resp_valid, d_resp_valid, i_err, d_err, mem_req_valid, mem_we, busy, owner} !== 8'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b want 00000000",
                     {i_resp_valid, d_resp_valid, i_err, d_err, mem_req_valid, mem_we, busy, owner});
        end
        vectors++;
        if ({i_rdata, d_rdata, mem_wdata, mem_addr} !== '0) begin
            miscompares++;
            $display("FAIL reset_data: i_rdata=%h d_rdata=%h mem_wdata=%h mem_addr=%0d want all 0",
                     i_rdata, d_rdata, mem_wdata, mem_addr);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_fetch_only();
        i_req = 1; i_addr = 3'd3; d_req = 0;
        tick();
        vectors++;
        if ({mem_req_valid, mem_we, mem_addr, owner, busy} !== {1'b1, 1'b0, 3'd3, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL fetch_req: got req=%b we=%b addr=%0d owner=%b busy=%b want 1 0 3 0 1",
                     mem_req_valid, mem_we, mem_addr, owner, busy);
        end
        tick();
        mem_data_valid = 1; mem_rdata = 32'hDEADBEEF;
        tick();
        mem_data_valid = 0; i_req = 0;
        vectors++;
        if ({i_resp_valid, d_resp_valid, i_err, mem_req_valid} !== 4'b1000 || i_rdata !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL fetch_resp: got iv=%b dv=%b err=%b req=%b rdata=%h want 1 0 0 0 deadbeef",
                     i_resp_valid, d_resp_valid, i_err, mem_req_valid, i_rdata);
        end
        tick();
        vectors++;
        if ({i_resp_valid, busy} !== 2'b00 || i_rdata !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL fetch_idle: got iv=%b busy=%b rdata=%h want 0 0 deadbeef",
                     i_resp_valid, busy, i_rdata);
        end
    endtask

    task automatic test_round_robin();
        reset = 1; tick(); reset = 0;
        i_req = 1; i_addr = 3'd1; d_req = 1; d_we = 1; d_addr = 3'd5; d_wdata = 32'h12345678;
        for (int k = 0; k < 4; k++) begin
            logic          exp_d;
            logic [AW-1:0] exp_a;
            exp_d = (k % 2) == 1;
            exp_a = exp_d ? 3'd5 : 3'd1;
            tick();
            vectors++;
            if ({mem_req_valid, owner, mem_we, mem_addr} !== {1'b1, exp_d, exp_d, exp_a}) begin
                miscompares++;
                $display("FAIL rr_grant%0d: got req=%b owner=%b we=%b addr=%0d want 1 %b %b %0d",
                         k, mem_req_valid, owner, mem_we, mem_addr, exp_d, exp_d, exp_a);
            end
            if (exp_d) begin
                vectors++;
                if (mem_wdata !== 32'h12345678) begin
                    miscompares++;
                    $display("FAIL rr_wdata%0d: got %h want 12345678", k, mem_wdata);
                end
            end
            mem_data_valid = 1; mem_rdata = 32'h100 + k;
            tick();
            mem_data_valid = 0;
            vectors++;
            if ({i_resp_valid, d_resp_valid} !== (exp_d ? 2'b01 : 2'b10)) begin
                miscompares++;
                $display("FAIL rr_resp%0d: got iv=%b dv=%b want owner %b", k, i_resp_valid, d_resp_valid, exp_d);
            end
            vectors++;
            if (!exp_d && i_rdata !== 32'h100 + k) begin
                miscompares++;
                $display("FAIL rr_irdata%0d: got %h want %h", k, i_rdata, 32'h100 + k);
            end else if (exp_d && d_rdata !== 32'h0) begin
                miscompares++;
                $display("FAIL rr_drdata%0d: got %h want 0 (write keeps rdata)", k, d_rdata);
            end
            tick();
            vectors++;
            if ({busy, mem_we, mem_req_valid} !== 3'b000) begin
                miscompares++;
                $display("FAIL rr_idle%0d: got busy=%b we=%b req=%b want 0 0 0", k, busy, mem_we, mem_req_valid);
            end
        end
        i_req = 0; d_req = 0; d_we = 0;
        tick();
    endtask

    task automatic test_stall();
        int pulses = 0;
        d_req = 1; d_we = 0; d_addr = 3'd6;
        for (int c = 0; c < 5; c++) begin
            tick();
            vectors++;
            if ({mem_req_valid, mem_addr, d_resp_valid} !== {1'b1, 3'd6, 1'b0}) begin
                miscompares++;
                $display("FAIL stall_c%0d: got req=%b addr=%0d dv=%b want 1 6 0",
                         c, mem_req_valid, mem_addr, d_resp_valid);
            end
            if (c == 4) begin mem_data_valid = 1; mem_rdata = 32'hCAFEF00D; end
        end
        tick();
        mem_data_valid = 0; d_req = 0;
        if (d_resp_valid) pulses++;
        vectors++;
        if ({d_resp_valid, d_err} !== 2'b10 || d_rdata !== 32'hCAFEF00D) begin
            miscompares++;
            $display("FAIL stall_resp: got dv=%b err=%b rdata=%h want 1 0 cafef00d", d_resp_valid, d_err, d_rdata);
        end
        tick();
        if (d_resp_valid) pulses++;
        vectors++;
        if (pulses !== 1) begin
            miscompares++;
            $display("FAIL stall_pulses: got %0d want 1", pulses);
        end
    endtask

    task automatic test_timeout();
        int high = 0;
        d_req = 1; d_we = 0; d_addr = 3'd2;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (!mem_req_valid) break;
            high++;
        end
        d_req = 0;
        vectors++;
        if (high !== 16) begin
            miscompares++;
            $display("FAIL timeout_len: got %0d cycles want 16", high);
        end
        vectors++;
        if ({d_resp_valid, d_err, i_resp_valid} !== 3'b110 || d_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL timeout_resp: got dv=%b err=%b iv=%b rdata=%h want 1 1 0 0",
                     d_resp_valid, d_err, i_resp_valid, d_rdata);
        end
        tick();
        d_req = 1;
        tick();
        mem_data_valid = 1; mem_rdata = 32'h55;
        tick();
        mem_data_valid = 0; d_req = 0;
        vectors++;
        if ({d_resp_valid, d_err} !== 2'b10 || d_rdata !== 32'h55) begin
            miscompares++;
            $display("FAIL after_timeout: got dv=%b err=%b rdata=%h want 1 0 55", d_resp_valid, d_err, d_rdata);
        end
        tick();
    endtask

    task automatic test_timeout_edge();
        d_req = 1; d_we = 0; d_addr = 3'd7;
        for (int c = 0; c < 16; c++) begin
            tick();
            if (c == 15) begin
                vectors++;
                if (mem_req_valid !== 1'b1) begin
                    miscompares++;
                    $display("FAIL edge_req: got %b want 1 on cycle 16", mem_req_valid);
                end
                mem_data_valid = 1; mem_rdata = 32'h77;
            end
        end
        tick();
        mem_data_valid = 0; d_req = 0;
        vectors++;
        if ({d_resp_valid, d_err} !== 2'b10 || d_rdata !== 32'h77) begin
            miscompares++;
            $display("FAIL edge_resp: got dv=%b err=%b rdata=%h want 1 0 77", d_resp_valid, d_err, d_rdata);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        i_req = 1; i_addr = 3'd4; d_req = 0;
        tick();
        vectors++;
        if ({mem_req_valid, owner} !== 2'b10) begin
            miscompares++;
            $display("FAIL mid_req: got req=%b owner=%b want 1 0", mem_req_valid, owner);
        end
        reset = 1; i_req = 0;
        tick();
        vectors++;
        if ({mem_req_valid, mem_we, busy, owner, i_resp_valid, d_resp_valid, i_err, d_err} !== 8'b0
            || {i_rdata, d_rdata, mem_wdata, mem_addr} !== '0) begin
            miscompares++;
            $display("FAIL mid_reset: got req=%b busy=%b owner=%b i_rdata=%h d_rdata=%h addr=%0d want all 0",
                     mem_req_valid, busy, owner, i_rdata, d_rdata, mem_addr);
        end
        reset = 0; mem_data_valid = 1; mem_rdata = 32'hBAD0BAD0;
        tick();
        mem_data_valid = 0;
        vectors++;
        if ({i_resp_valid, d_resp_valid, busy} !== 3'b000) begin
            miscompares++;
            $display("FAIL mid_late: got iv=%b dv=%b busy=%b want 0 0 0", i_resp_valid, d_resp_valid, busy);
        end
        i_req = 1; i_addr = 3'd2; d_req = 1; d_we = 1; d_addr = 3'd5;
        tick();
        vectors++;
        if ({mem_req_valid, owner, mem_addr} !== {1'b1, 1'b0, 3'd2}) begin
            miscompares++;
            $display("FAIL mid_tie: got req=%b owner=%b addr=%0d want 1 0 2", mem_req_valid, owner, mem_addr);
        end
        mem_data_valid = 1; mem_rdata = 32'h99;
        i_req = 0; d_req = 0;
        tick();
        mem_data_valid = 0;
        vectors++;
        if ({i_resp_valid, i_rdata} !== {1'b1, 32'h99}) begin
            miscompares++;
            $display("FAIL mid_tie_resp: got iv=%b rdata=%h want 1 99", i_resp_valid, i_rdata);
        end
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fetch_only();
        test_round_robin();
        test_stall();
        test_timeout();
        test_timeout_edge();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
